// File: rtl/itch_pkg.sv
// Shared ITCH 5.0 definitions: message codes, Add Order field offsets, staging record and
// parser state encoding.
package itch_pkg;

    localparam logic [7:0] MSG_ADD_ORDER = 8'h41;
    localparam logic [7:0] SIDE_BUY      = 8'h42;

    // Body offsets (body byte 0 is the message type)
    localparam logic [15:0] OFF_LOCATE     = 16'd1;
    localparam logic [15:0] OFF_LOCATE_END = 16'd2;
    localparam logic [15:0] OFF_TS         = 16'd5;
    localparam logic [15:0] OFF_TS_END     = 16'd10;
    localparam logic [15:0] OFF_REF        = 16'd11;
    localparam logic [15:0] OFF_REF_END    = 16'd18;
    localparam logic [15:0] OFF_SIDE       = 16'd19;
    localparam logic [15:0] OFF_SHARES     = 16'd20;
    localparam logic [15:0] OFF_SHARES_END = 16'd23;
    localparam logic [15:0] OFF_STOCK      = 16'd24;
    localparam logic [15:0] OFF_STOCK_END  = 16'd31;
    localparam logic [15:0] OFF_PRICE      = 16'd32;
    localparam logic [15:0] OFF_PRICE_END  = 16'd35;

    typedef struct packed {
        logic [47:0] timestamp;
        logic [15:0] stock_locate;
        logic [63:0] order_ref;
        logic        side;
        logic [31:0] shares;
        logic [63:0] stock;
        logic [31:0] price;
    } itch_add_order_t;

    typedef enum logic [1:0] {
        StLenHi,
        StLenLo,
        StBody,
        StWaitCrc
    } parser_state_e;

    function automatic logic in_range(input logic [15:0] cnt, input logic [15:0] lo,
                                      input logic [15:0] hi);
        return (cnt >= lo) && (cnt <= hi);
    endfunction

endpackage

// File: rtl/itch_add_order_parser.sv
// Parses length-prefixed ITCH payload, stages Add Order fields and publishes them only once
// the frame FCS verdict is good; drop reasons are tallied in saturating counters.
module itch_add_order_parser
    import itch_pkg::*;
#(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned ADD_LEN = 36
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       payload_byte,
    input  logic             payload_valid,
    output logic             payload_ready,
    input  logic             crc_valid,
    input  logic             crc_ok,
    output logic             msg_valid,
    output logic [47:0]      msg_timestamp,
    output logic [15:0]      msg_stock_locate,
    output logic [63:0]      msg_order_ref,
    output logic             msg_side,
    output logic [31:0]      msg_shares,
    output logic [63:0]      msg_stock,
    output logic [31:0]      msg_price,
    output logic [CNT_W-1:0] cnt_accepted,
    output logic [CNT_W-1:0] cnt_drop_crc,
    output logic [CNT_W-1:0] cnt_drop_other
);

    localparam logic [15:0] ADD_LEN_W = 16'(ADD_LEN);

    parser_state_e   state_q, state_d;
    logic [15:0]     len_q, len_d;
    logic [15:0]     body_cnt_q, body_cnt_d;
    logic            is_add_q, is_add_d;
    itch_add_order_t stage_q, stage_d;
    itch_add_order_t msg_q, msg_d;
    logic            msg_valid_q, msg_valid_d;
    logic            ready_q;
    logic [CNT_W-1:0] cnt_acc_q, cnt_crc_q, cnt_oth_q;
    logic            inc_acc, inc_crc, inc_oth;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        body_cnt_d  = body_cnt_q;
        is_add_d    = is_add_q;
        stage_d     = stage_q;
        msg_d       = msg_q;
        msg_valid_d = 1'b0;
        inc_acc     = 1'b0;
        inc_crc     = 1'b0;
        inc_oth     = 1'b0;

        if (crc_valid) begin
            // The verdict wins; a byte arriving alongside it belongs to no frame.
            unique case (state_q)
                StLenHi: state_d = StLenHi;
                StLenLo, StBody: begin
                    inc_oth = 1'b1;
                    state_d = StLenHi;
                end
                StWaitCrc: begin
                    if (!is_add_q) begin
                        inc_oth = 1'b1;
                    end else if (crc_ok) begin
                        msg_d       = stage_q;
                        msg_valid_d = 1'b1;
                        inc_acc     = 1'b1;
                    end else begin
                        inc_crc = 1'b1;
                    end
                    state_d = StLenHi;
                end
                default: state_d = StLenHi;
            endcase
            if (payload_valid) begin
                inc_oth = 1'b1;
            end
        end else if (payload_valid) begin
            unique case (state_q)
                StLenHi: begin
                    len_d[15:8] = payload_byte;
                    state_d     = StLenLo;
                end
                StLenLo: begin
                    len_d[7:0] = payload_byte;
                    body_cnt_d = 16'd0;
                    if ({len_q[15:8], payload_byte} == 16'd0) begin
                        is_add_d = 1'b0;
                        state_d  = StWaitCrc;
                    end else begin
                        state_d = StBody;
                    end
                end
                StBody: begin
                    if (body_cnt_q == 16'd0) begin
                        is_add_d = (payload_byte == MSG_ADD_ORDER) && (len_q == ADD_LEN_W);
                    end else if (is_add_q) begin
                        if (in_range(body_cnt_q, OFF_LOCATE, OFF_LOCATE_END)) begin
                            stage_d.stock_locate = {stage_q.stock_locate[7:0], payload_byte};
                        end
                        if (in_range(body_cnt_q, OFF_TS, OFF_TS_END)) begin
                            stage_d.timestamp = {stage_q.timestamp[39:0], payload_byte};
                        end
                        if (in_range(body_cnt_q, OFF_REF, OFF_REF_END)) begin
                            stage_d.order_ref = {stage_q.order_ref[55:0], payload_byte};
                        end
                        if (body_cnt_q == OFF_SIDE) begin
                            stage_d.side = (payload_byte == SIDE_BUY);
                        end
                        if (in_range(body_cnt_q, OFF_SHARES, OFF_SHARES_END)) begin
                            stage_d.shares = {stage_q.shares[23:0], payload_byte};
                        end
                        if (in_range(body_cnt_q, OFF_STOCK, OFF_STOCK_END)) begin
                            stage_d.stock = {stage_q.stock[55:0], payload_byte};
                        end
                        if (in_range(body_cnt_q, OFF_PRICE, OFF_PRICE_END)) begin
                            stage_d.price = {stage_q.price[23:0], payload_byte};
                        end
                    end
                    body_cnt_d = body_cnt_q + 16'd1;
                    if (body_cnt_q == len_q - 16'd1) begin
                        state_d = StWaitCrc;
                    end
                end
                StWaitCrc: begin
                    inc_oth = 1'b1;
                    state_d = StLenHi;
                end
                default: state_d = StLenHi;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StLenHi;
            len_q       <= 16'd0;
            body_cnt_q  <= 16'd0;
            is_add_q    <= 1'b0;
            stage_q     <= '0;
            msg_q       <= '0;
            msg_valid_q <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            body_cnt_q  <= body_cnt_d;
            is_add_q    <= is_add_d;
            stage_q     <= stage_d;
            msg_q       <= msg_d;
            msg_valid_q <= msg_valid_d;
            ready_q     <= 1'b1;
        end
    end

    // Statistics stick at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_acc_q <= '0;
            cnt_crc_q <= '0;
            cnt_oth_q <= '0;
        end else begin
            if (inc_acc && (cnt_acc_q != '1)) cnt_acc_q <= cnt_acc_q + CNT_W'(1);
            if (inc_crc && (cnt_crc_q != '1)) cnt_crc_q <= cnt_crc_q + CNT_W'(1);
            if (inc_oth && (cnt_oth_q != '1)) cnt_oth_q <= cnt_oth_q + CNT_W'(1);
        end
    end

    assign payload_ready    = ready_q;
    assign msg_valid        = msg_valid_q;
    assign msg_timestamp    = msg_q.timestamp;
    assign msg_stock_locate = msg_q.stock_locate;
    assign msg_order_ref    = msg_q.order_ref;
    assign msg_side         = msg_q.side;
    assign msg_shares       = msg_q.shares;
    assign msg_stock        = msg_q.stock;
    assign msg_price        = msg_q.price;
    assign cnt_accepted     = cnt_acc_q;
    assign cnt_drop_crc     = cnt_crc_q;
    assign cnt_drop_other   = cnt_oth_q;

endmodule

// File: tb/tb_itch_add_order_parser.sv
// Randomized frame-level bench: a byte-array model of each frame predicts publish/drop outcomes.
module tb_itch_add_order_parser;

    localparam int unsigned CNT_W = 5;
    localparam int CMAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [7:0]       payload_byte = 8'h00;
    logic             payload_valid = 1'b0;
    logic             payload_ready;
    logic             crc_valid = 1'b0;
    logic             crc_ok = 1'b0;
    logic             msg_valid;
    logic [47:0]      msg_timestamp;
    logic [15:0]      msg_stock_locate;
    logic [63:0]      msg_order_ref;
    logic             msg_side;
    logic [31:0]      msg_shares;
    logic [63:0]      msg_stock;
    logic [31:0]      msg_price;
    logic [CNT_W-1:0] cnt_accepted;
    logic [CNT_W-1:0] cnt_drop_crc;
    logic [CNT_W-1:0] cnt_drop_other;

    itch_add_order_parser #(.CNT_W(CNT_W), .ADD_LEN(36)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .payload_byte    (payload_byte),
        .payload_valid   (payload_valid),
        .payload_ready   (payload_ready),
        .crc_valid       (crc_valid),
        .crc_ok          (crc_ok),
        .msg_valid       (msg_valid),
        .msg_timestamp   (msg_timestamp),
        .msg_stock_locate(msg_stock_locate),
        .msg_order_ref   (msg_order_ref),
        .msg_side        (msg_side),
        .msg_shares      (msg_shares),
        .msg_stock       (msg_stock),
        .msg_price       (msg_price),
        .cnt_accepted    (cnt_accepted),
        .cnt_drop_crc    (cnt_drop_crc),
        .cnt_drop_other  (cnt_drop_other)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    logic [7:0] frame[$];

    // Expected DUT outputs
    logic        exp_valid, exp_ready;
    logic [47:0] e_ts;
    logic [15:0] e_loc;
    logic [63:0] e_ref;
    logic        e_side;
    logic [31:0] e_sh;
    logic [63:0] e_stk;
    logic [31:0] e_pr;
    int          e_acc, e_crc, e_oth;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("msg_valid", 64'(msg_valid), 64'(exp_valid));
            chk("payload_ready", 64'(payload_ready), 64'(exp_ready));
            chk("msg_timestamp", 64'(msg_timestamp), 64'(e_ts));
            chk("msg_stock_locate", 64'(msg_stock_locate), 64'(e_loc));
            chk("msg_order_ref", msg_order_ref, e_ref);
            chk("msg_side", 64'(msg_side), 64'(e_side));
            chk("msg_shares", 64'(msg_shares), 64'(e_sh));
            chk("msg_stock", msg_stock, e_stk);
            chk("msg_price", 64'(msg_price), 64'(e_pr));
            chk("cnt_accepted", 64'(cnt_accepted), 64'(e_acc));
            chk("cnt_drop_crc", 64'(cnt_drop_crc), 64'(e_crc));
            chk("cnt_drop_other", 64'(cnt_drop_other), 64'(e_oth));
        end
    end

    function automatic int sat(input int c);
        return (c < CMAX) ? c + 1 : c;
    endfunction

    task automatic model_clear();
        exp_valid = 1'b0;
        exp_ready = 1'b0;
        e_ts = '0; e_loc = '0; e_ref = '0; e_side = 1'b0;
        e_sh = '0; e_stk = '0; e_pr = '0;
        e_acc = 0; e_crc = 0; e_oth = 0;
    endtask

    // Big-endian field read from the ITCH body (body byte 0 = type)
    function automatic logic [63:0] get_be(input int off, input int n);
        logic [63:0] v = '0;
        for (int i = 0; i < n; i++) v = (v << 8) | 64'(frame[2 + off + i]);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        exp_valid = 1'b0;
    endtask

    task automatic push_be(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) frame.push_back(v[8*i +: 8]);
    endtask

    task automatic build_add(input logic [15:0] loc, input logic [47:0] ts, input logic [63:0] oref,
                             input logic [7:0] side, input logic [31:0] sh, input logic [63:0] stk,
                             input logic [31:0] pr);
        frame.delete();
        push_be(64'd36, 2);
        frame.push_back(8'h41);
        push_be(64'(loc), 2);
        push_be(64'($urandom_range(0, 65535)), 2);
        push_be(64'(ts), 6);
        push_be(oref, 8);
        frame.push_back(side);
        push_be(64'(sh), 4);
        push_be(stk, 8);
        push_be(64'(pr), 4);
    endtask

    task automatic build_other(input int len, input logic [7:0] typ);
        frame.delete();
        push_be(64'(len), 2);
        if (len > 0) frame.push_back(typ);
        for (int i = 1; i < len; i++) frame.push_back(8'($urandom_range(0, 255)));
    endtask

    // Outcome of a crc_valid strobe after `sent` bytes of `frame` were delivered.
    task automatic model_crc(input int sent, input bit ok);
        int len;
        len = int'({frame[0], frame[1]});
        if (sent == 0) return;
        if (sent < 2 + len || len == 0) begin
            e_oth = sat(e_oth);
        end else if (len == 36 && frame[2] == 8'h41) begin
            if (ok) begin
                e_loc  = 16'(get_be(1, 2));
                e_ts   = 48'(get_be(5, 6));
                e_ref  = get_be(11, 8);
                e_side = (frame[2 + 19] == 8'h42);
                e_sh   = 32'(get_be(20, 4));
                e_stk  = get_be(24, 8);
                e_pr   = 32'(get_be(32, 4));
                exp_valid = 1'b1;
                e_acc  = sat(e_acc);
            end else begin
                e_crc = sat(e_crc);
            end
        end else begin
            e_oth = sat(e_oth);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            payload_valid = 1'b0;
            payload_byte  = 8'($urandom_range(0, 255));
            crc_ok        = 1'($urandom_range(0, 1));
            tick();
        end
    endtask

    task automatic send(input int sent, input int gap_max, input int crc_dly, input bit ok,
                        input bit extra);
        for (int i = 0; i < sent; i++) begin
            idle($urandom_range(0, gap_max));
            payload_valid = 1'b1;
            payload_byte  = frame[i];
            tick();
        end
        payload_valid = 1'b0;
        if (extra) begin
            payload_valid = 1'b1;
            payload_byte  = 8'($urandom_range(0, 255));
            tick();
            payload_valid = 1'b0;
            e_oth = sat(e_oth);
        end
        idle(crc_dly);
        crc_valid = 1'b1;
        crc_ok    = ok;
        tick();
        crc_valid = 1'b0;
        model_crc(extra ? 0 : sent, ok);
    endtask

    task automatic random_add(input logic [63:0] oref);
        build_add(16'($urandom), {16'($urandom), 32'($urandom)}, oref,
                  ($urandom_range(0, 1) != 0) ? 8'h42 : 8'h53, 32'($urandom),
                  {32'($urandom), 32'($urandom)}, 32'($urandom));
    endtask

    logic [63:0] aapl = "AAPL    ";

    initial begin
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        repeat (2) tick();
        chk("reset msg_valid", 64'(msg_valid), 64'd0);
        chk("reset payload_ready", 64'(payload_ready), 64'd0);
        rst_n = 1'b1;
        tick();
        exp_ready = 1'b1;
        tick();

        // Good Add Order
        build_add(16'd7, 48'h0000_1234_5678, 64'h0102030405060708, 8'h42, 32'd100, aapl,
                  32'd1500000);
        send(frame.size(), 0, 3, 1'b1, 1'b0);
        chk("good msg_valid", 64'(msg_valid), 64'd1);
        chk("good order_ref", msg_order_ref, 64'h0102030405060708);
        chk("good side", 64'(msg_side), 64'd1);
        chk("good shares", 64'(msg_shares), 64'd100);
        chk("good stock", msg_stock, 64'h4141504C20202020);
        chk("good price", 64'(msg_price), 64'd1500000);
        chk("good timestamp", 64'(msg_timestamp), 64'h0000_1234_5678);
        chk("good cnt_accepted", 64'(cnt_accepted), 64'd1);
        idle(2);

        // Same frame, bad FCS
        send(frame.size(), 0, 3, 1'b0, 1'b0);
        chk("badcrc msg_valid", 64'(msg_valid), 64'd0);
        chk("badcrc order_ref held", msg_order_ref, 64'h0102030405060708);
        chk("badcrc cnt_drop_crc", 64'(cnt_drop_crc), 64'd1);
        idle(2);

        // 'E' message then a good 'A'
        build_other(31, 8'h45);
        send(frame.size(), 1, 2, 1'b1, 1'b0);
        chk("E cnt_drop_other", 64'(cnt_drop_other), 64'd1);
        chk("E msg_valid", 64'(msg_valid), 64'd0);
        random_add(64'h1111);
        send(frame.size(), 1, 1, 1'b1, 1'b0);
        chk("after E accepted", 64'(cnt_accepted), 64'd2);

        // Truncated after 20 body bytes, then good
        random_add(64'h2222);
        send(22, 0, 1, 1'b1, 1'b0);
        chk("trunc cnt_drop_other", 64'(cnt_drop_other), 64'd2);
        random_add(64'h3333);
        send(frame.size(), 0, 0, 1'b1, 1'b0);
        chk("after trunc order_ref", msg_order_ref, 64'h3333);

        // Zero-length frame, then back-to-back good frames
        build_other(0, 8'h00);
        send(2, 0, 1, 1'b1, 1'b0);
        chk("len0 cnt_drop_other", 64'(cnt_drop_other), 64'd3);
        random_add(64'hAAAA);
        send(frame.size(), 0, 0, 1'b1, 1'b0);
        chk("b2b first ref", msg_order_ref, 64'hAAAA);
        idle(1);
        random_add(64'hBBBB);
        send(frame.size(), 0, 0, 1'b1, 1'b0);
        chk("b2b second ref", msg_order_ref, 64'hBBBB);
        chk("b2b cnt_accepted", 64'(cnt_accepted), 64'd5);

        // crc_valid with no payload in flight: nothing counted
        idle(1);
        crc_valid = 1'b1;
        tick();
        crc_valid = 1'b0;
        idle(1);

        // Randomized traffic; counters reach saturation here
        for (int f = 0; f < 220; f++) begin
            int kind;
            kind = $urandom_range(0, 5);
            case (kind)
                0: begin random_add({32'($urandom), 32'($urandom)});
                         send(frame.size(), 2, $urandom_range(0, 4), 1'b1, 1'b0); end
                1: begin random_add({32'($urandom), 32'($urandom)});
                         send(frame.size(), 2, $urandom_range(0, 4), 1'b0, 1'b0); end
                2: begin
                    if ($urandom_range(0, 1) != 0) build_other($urandom_range(1, 50), 8'h41);
                    else build_other($urandom_range(1, 50), 8'($urandom_range(66, 90)));
                    send(frame.size(), 1, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0);
                end
                3: begin random_add({32'($urandom), 32'($urandom)});
                         send($urandom_range(0, 37), 1, $urandom_range(0, 3), 1'b1, 1'b0); end
                4: begin build_other(0, 8'h00); send(2, 1, $urandom_range(0, 3), 1'b1, 1'b0); end
                default: begin random_add({32'($urandom), 32'($urandom)});
                               send(frame.size(), 1, $urandom_range(0, 3), 1'b1, 1'b1); end
            endcase
            idle($urandom_range(0, 2));
        end
        chk("saturated cnt_drop_other", 64'(cnt_drop_other), 64'(CMAX));

        // Reset in the middle of a body
        random_add(64'h5555);
        for (int i = 0; i < 15; i++) begin
            payload_valid = 1'b1;
            payload_byte  = frame[i];
            tick();
        end
        payload_valid = 1'b0;
        rst_n = 1'b0;
        model_clear();
        repeat (2) tick();
        chk("midreset cnt_accepted", 64'(cnt_accepted), 64'd0);
        chk("midreset cnt_drop_other", 64'(cnt_drop_other), 64'd0);
        chk("midreset order_ref", msg_order_ref, 64'd0);
        chk("midreset payload_ready", 64'(payload_ready), 64'd0);
        rst_n = 1'b1;
        tick();
        exp_ready = 1'b1;
        random_add(64'h6666);
        send(frame.size(), 0, 2, 1'b1, 1'b0);
        chk("postreset cnt_accepted", 64'(cnt_accepted), 64'd1);
        chk("postreset order_ref", msg_order_ref, 64'h6666);
        idle(3);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
